// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and the
// HALT encoding that the instruction memory also recognises.
package instruction_loader_pkg;

  localparam int STATE_W = 3;

  localparam logic [31:0] DEFAULT_HALT_INSTRUCTION = 32'hFFFF_FFFF;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECEIVE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory signals of the loader, bundled so the
// loader (slave) and the host/memory side (master) see one connection.
interface instruction_loader_if #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64
);
  import instruction_loader_pkg::*;

  localparam int WORD_W = WORD_SIZE_IN_BYTES * 8;
  localparam int CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              i_mem_full;
  logic              o_mem_clear;
  logic              o_instruction_write;
  logic [WORD_W-1:0] o_instruction;
  logic [CNT_W-1:0]  o_word_count;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  modport slave (
    input  i_start, i_byte_valid, i_byte, i_mem_full,
    output o_byte_ready, o_mem_clear, o_instruction_write, o_instruction,
           o_word_count, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_byte_valid, i_byte, i_mem_full,
    input  o_byte_ready, o_mem_clear, o_instruction_write, o_instruction,
           o_word_count, o_busy, o_done, o_error
  );

endinterface

// File: rtl/instruction_loader_byte_word_assembler.sv
// Packs accepted bytes little-endian into one instruction word and flags the
// acceptance of the final byte of that word.
module instruction_loader_byte_word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_clear,
  input  logic                            i_accept,
  input  logic [7:0]                      i_byte,
  output logic [WORD_SIZE_IN_BYTES*8-1:0] o_word,
  output logic                            o_word_complete
);

  localparam int IDX_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE_IN_BYTES - 1);

  logic [IDX_W-1:0]                index_q, index_d;
  logic [WORD_SIZE_IN_BYTES*8-1:0] word_q, word_d;

  always_comb begin
    index_d         = index_q;
    word_d          = word_q;
    o_word_complete = 1'b0;
    if (i_clear) begin
      index_d = '0;
      word_d  = '0;
    end else if (i_accept) begin
      word_d[8*int'(index_q) +: 8] = i_byte;
      if (index_q == LAST_IDX) begin
        index_d         = '0;
        o_word_complete = 1'b1;
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      index_q <= '0;
      word_q  <= '0;
    end else begin
      index_q <= index_d;
      word_q  <= word_d;
    end
  end

  assign o_word = word_q;

endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a byte stream: clear, then
// one write strobe per assembled word with an idle gap, ending on HALT or overflow.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  parameter logic [WORD_SIZE_IN_BYTES*8-1:0] HALT_INSTRUCTION =
    (WORD_SIZE_IN_BYTES*8)'(DEFAULT_HALT_INSTRUCTION)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_loader_if.slave  bus
);

  localparam int WORD_W = WORD_SIZE_IN_BYTES * 8;
  localparam int CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [WORD_W-1:0] instruction_q, instruction_d;
  logic              asm_clear, asm_accept, asm_complete;
  logic [WORD_W-1:0] asm_word;

  instruction_loader_byte_word_assembler #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
  ) u_assembler (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (asm_clear),
    .i_accept       (asm_accept),
    .i_byte         (bus.i_byte),
    .o_word         (asm_word),
    .o_word_complete(asm_complete)
  );

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    instruction_d = instruction_q;
    asm_clear     = 1'b0;
    asm_accept    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.i_start) begin
          state_d      = ST_CLEAR;
          word_count_d = '0;
          asm_clear    = 1'b1;
        end
      end
      ST_CLEAR: state_d = ST_RECEIVE;
      ST_RECEIVE: begin
        asm_accept = bus.i_byte_valid;
        if (asm_complete) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        instruction_d = asm_word;
        word_count_d  = word_count_q + CNT_W'(1);
        state_d       = ST_GAP;
      end
      // HALT outranks the capacity check so a HALT landing in the last slot still completes
      ST_GAP: begin
        if (instruction_q == HALT_INSTRUCTION) begin
          state_d = ST_DONE;
        end else if ((word_count_q == CNT_W'(MEM_SIZE_IN_WORDS)) || bus.i_mem_full) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_RECEIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      word_count_q  <= '0;
      instruction_q <= '0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      instruction_q <= instruction_d;
    end
  end

  assign bus.o_byte_ready        = (state_q == ST_RECEIVE);
  assign bus.o_mem_clear         = (state_q == ST_CLEAR);
  assign bus.o_instruction_write = (state_q == ST_WRITE);
  assign bus.o_instruction       = (state_q == ST_WRITE) ? asm_word : instruction_q;
  assign bus.o_word_count        = word_count_q;
  assign bus.o_busy              = (state_q == ST_CLEAR) || (state_q == ST_RECEIVE) ||
                                   (state_q == ST_WRITE) || (state_q == ST_GAP);
  assign bus.o_done              = (state_q == ST_DONE);
  assign bus.o_error             = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a four-word memory; a scoreboard
// queue holds the words expected on each write strobe.
module tb_instruction_loader;

  localparam int WSB = 4;
  localparam int MEM = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic reset;

  instruction_loader_if #(.WORD_SIZE_IN_BYTES(WSB), .MEM_SIZE_IN_WORDS(MEM)) bus ();

  instruction_loader #(
    .WORD_SIZE_IN_BYTES(WSB),
    .MEM_SIZE_IN_WORDS (MEM)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int clearCount = 0;
  int strobeCount = 0;
  logic prevWrite = 1'b0;
  logic [31:0] expQ[$];
  logic [31:0] expWord;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every strobe must be single-cycle, carry the next scoreboard word, and never overlap ready
  always @(negedge clk) begin
    if (bus.o_mem_clear) clearCount++;
    if (bus.o_instruction_write) begin
      strobeCount++;
      checkOutput("strobe_spacing", 32'(prevWrite), 0);
      checkOutput("ready_in_write", 32'(bus.o_byte_ready), 0);
      checkOutput("strobe_pending", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        expWord = expQ.pop_front();
        checkOutput("strobe_word", bus.o_instruction, expWord);
      end
    end
    prevWrite = bus.o_instruction_write;
  end

  task automatic doStart();
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.i_byte_valid = 1'b0;
        bus.i_byte = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    bus.i_byte_valid = 1'b1;
    bus.i_byte = b;
    budget = 0;
    @(negedge clk);
    while (!bus.o_byte_ready && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.o_byte_ready) checkOutput("byte_accept", 32'(bus.o_byte_ready), 1);
    @(posedge clk);
    #1 bus.i_byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] word, input bit gaps, input bit expectStrobe);
    if (expectStrobe) expQ.push_back(word);
    for (int k = 0; k < WSB; k++) sendByte(word[8*k +: 8], gaps);
  endtask

  task automatic waitLevel(input string tag, input bit wantDone);
    int n = 0;
    @(negedge clk);
    while (!(wantDone ? bus.o_done : bus.o_error) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(wantDone ? bus.o_done : bus.o_error), 1);
  endtask

  initial begin
    int c0;
    int s0;
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte = 8'h00;
    bus.i_mem_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_busy", 32'(bus.o_busy), 0);
    checkOutput("rst_done", 32'(bus.o_done), 0);
    checkOutput("rst_error", 32'(bus.o_error), 0);
    checkOutput("rst_count", 32'(bus.o_word_count), 0);
    checkOutput("rst_ready", 32'(bus.o_byte_ready), 0);
    checkOutput("rst_write", 32'(bus.o_instruction_write), 0);
    checkOutput("rst_clear", 32'(bus.o_mem_clear), 0);
    checkOutput("rst_instr", bus.o_instruction, 0);

    $display("[TB] reset during a partial word");
    doStart();
    sendByte(8'hAA, 1'b0);
    sendByte(8'hBB, 1'b0);
    doReset();
    @(negedge clk);
    checkOutput("midrst_busy", 32'(bus.o_busy), 0);
    checkOutput("midrst_count", 32'(bus.o_word_count), 0);
    checkOutput("midrst_ready", 32'(bus.o_byte_ready), 0);

    $display("[TB] three-word little-endian program");
    c0 = clearCount;
    s0 = strobeCount;
    doStart();
    applyStimulus(32'h2008_0013, 1'b0, 1'b1);
    applyStimulus(32'h0000_0000, 1'b0, 1'b1);
    applyStimulus(HALT, 1'b0, 1'b1);
    waitLevel("prog3_done", 1'b1);
    checkOutput("prog3_count", 32'(bus.o_word_count), 3);
    checkOutput("prog3_error", 32'(bus.o_error), 0);
    checkOutput("prog3_strobes", 32'(strobeCount - s0), 3);
    checkOutput("prog3_clears", 32'(clearCount - c0), 1);
    checkOutput("prog3_sb_empty", 32'(expQ.size()), 0);

    $display("[TB] restart with single HALT, latency check");
    doStart();
    @(negedge clk);
    checkOutput("halt_clear", 32'(bus.o_mem_clear), 1);
    checkOutput("halt_count_zero", 32'(bus.o_word_count), 0);
    applyStimulus(HALT, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("halt_write", 32'(bus.o_instruction_write), 1);
    checkOutput("halt_instr", bus.o_instruction, HALT);
    @(negedge clk);
    checkOutput("halt_gap_write", 32'(bus.o_instruction_write), 0);
    checkOutput("halt_gap_ready", 32'(bus.o_byte_ready), 0);
    checkOutput("halt_gap_done", 32'(bus.o_done), 0);
    checkOutput("halt_gap_count", 32'(bus.o_word_count), 1);
    @(negedge clk);
    checkOutput("halt_done", 32'(bus.o_done), 1);
    checkOutput("halt_busy", 32'(bus.o_busy), 0);
    checkOutput("halt_count", 32'(bus.o_word_count), 1);

    $display("[TB] three-word program with random valid gaps");
    doStart();
    applyStimulus(32'h2008_0013, 1'b1, 1'b1);
    applyStimulus(32'h0000_0000, 1'b1, 1'b1);
    applyStimulus(HALT, 1'b1, 1'b1);
    waitLevel("gaps_done", 1'b1);
    checkOutput("gaps_count", 32'(bus.o_word_count), 3);

    $display("[TB] capacity overflow");
    s0 = strobeCount;
    doStart();
    applyStimulus(32'hA5A5_0001, 1'b0, 1'b1);
    applyStimulus(32'h1234_5678, 1'b0, 1'b1);
    applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus(32'h0F0F_F0F0, 1'b0, 1'b1);
    waitLevel("ovf_error", 1'b0);
    checkOutput("ovf_done", 32'(bus.o_done), 0);
    checkOutput("ovf_count", 32'(bus.o_word_count), 4);
    bus.i_byte_valid = 1'b1;
    bus.i_byte = 8'h55;
    repeat (12) @(posedge clk);
    #1 bus.i_byte_valid = 1'b0;
    @(negedge clk);
    checkOutput("ovf_strobes", 32'(strobeCount - s0), 4);
    checkOutput("ovf_ready", 32'(bus.o_byte_ready), 0);
    checkOutput("ovf_hold_error", 32'(bus.o_error), 1);
    checkOutput("ovf_hold_count", 32'(bus.o_word_count), 4);

    $display("[TB] HALT as the last word of memory");
    doStart();
    applyStimulus(32'h0000_0011, 1'b0, 1'b1);
    applyStimulus(32'h0000_0022, 1'b0, 1'b1);
    applyStimulus(32'h0000_0033, 1'b0, 1'b1);
    applyStimulus(HALT, 1'b0, 1'b1);
    waitLevel("lasthalt_done", 1'b1);
    checkOutput("lasthalt_error", 32'(bus.o_error), 0);
    checkOutput("lasthalt_count", 32'(bus.o_word_count), 4);

    $display("[TB] memory full after second word");
    doStart();
    applyStimulus(32'hCAFE_0001, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 bus.i_mem_full = 1'b1;
    applyStimulus(32'hCAFE_0002, 1'b0, 1'b1);
    waitLevel("full_error", 1'b0);
    checkOutput("full_count", 32'(bus.o_word_count), 2);
    bus.i_mem_full = 1'b0;

    $display("[TB] restart from error");
    doStart();
    @(negedge clk);
    checkOutput("rerr_clear", 32'(bus.o_mem_clear), 1);
    checkOutput("rerr_count_zero", 32'(bus.o_word_count), 0);
    checkOutput("rerr_error_low", 32'(bus.o_error), 0);
    applyStimulus(32'h0000_0093, 1'b1, 1'b1);
    applyStimulus(HALT, 1'b1, 1'b1);
    waitLevel("rerr_done", 1'b1);
    checkOutput("rerr_count", 32'(bus.o_word_count), 2);
    checkOutput("final_sb_empty", 32'(expQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
